// File: rtl/tx_packet_framer.sv
// rtl/tx_packet_framer.sv - serialises a packet snapshot into a byte frame with CRC-16 and terminator
// Hex-ASCII or raw-binary framing; valid/ready on both sides, one packet in flight.
module tx_packet_framer #(
    parameter int         PACKET_SIZE = 256,
    parameter bit         BINARY      = 1'b0,
    parameter logic [7:0] TERMINATOR  = 8'h0D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_SIZE-1:0] packet,
    input  logic                   packet_valid,
    output logic                   packet_ready,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [15:0]            crc_out,
    output logic                   overrun
);
    localparam int CW         = $clog2(PACKET_SIZE/4 + 1);
    localparam int DATA_UNITS = BINARY ? PACKET_SIZE/8 : PACKET_SIZE/4;
    localparam int CRC_UNITS  = BINARY ? 2 : 4;
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_UNITS - 1);
    localparam logic [CW-1:0] CRC_LAST  = CW'(CRC_UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_TERM} state_t;

    state_t                 state_q, state_d;
    logic [PACKET_SIZE-1:0] shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [15:0]            crc_q, crc_d;
    logic [15:0]            crc_out_q, crc_out_d;
    logic                   overrun_q, overrun_d;
    logic                   pv_q, pv_d;

    logic [7:0] data_byte;
    logic [7:0] crc_byte;
    logic [3:0] crc_nib;
    logic [7:0] tx_byte_c;
    logic       hs;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    crc_nib = crc_q[15:12];
            2'd1:    crc_nib = crc_q[11:8];
            2'd2:    crc_nib = crc_q[7:4];
            default: crc_nib = crc_q[3:0];
        endcase
        data_byte = BINARY ? shift_q[PACKET_SIZE-1 -: 8] : hex_char(shift_q[PACKET_SIZE-1 -: 4]);
        crc_byte  = BINARY ? (cnt_q[0] ? crc_q[7:0] : crc_q[15:8]) : hex_char(crc_nib);
    end

    assign hs = (state_q != S_IDLE) && tx_ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        overrun_d = overrun_q;
        pv_d      = packet_valid;
        tx_byte_c = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (packet_valid) begin
                    shift_d = packet;
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_byte_c = data_byte;
                if (hs) begin
                    crc_d   = crc_step(crc_q, data_byte);
                    shift_d = BINARY ? (shift_q << 8) : (shift_q << 4);
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CRC: begin
                tx_byte_c = crc_byte;
                if (hs) begin
                    if (cnt_q == CRC_LAST) begin
                        cnt_d   = '0;
                        state_d = S_TERM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_byte_c = TERMINATOR;
                if (hs) begin
                    crc_out_d = crc_q;
                    state_d   = S_IDLE;
                end
            end
        endcase

        // A producer holding valid after its accept is streaming, not overrunning; only a fresh offer counts.
        if ((state_q != S_IDLE) && packet_valid && !pv_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            crc_q     <= 16'hFFFF;
            crc_out_q <= 16'h0000;
            overrun_q <= 1'b0;
            pv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            overrun_q <= overrun_d;
            pv_q      <= pv_d;
        end
    end

    assign packet_ready = (state_q == S_IDLE);
    assign tx_valid     = (state_q != S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign tx_byte      = tx_byte_c;
    assign crc_out      = crc_out_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_tx_packet_framer.sv
// tb/tb_tx_packet_framer.sv - self-checking bench for tx_packet_framer (binary 72-bit and hex 16-bit instances)
module tb_tx_packet_framer;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [71:0] pkt_b = '0;
    logic        pv_b = 1'b0, pr_b, tv_b, trdy_b = 1'b0, busy_b, ovr_b;
    logic [7:0]  txb_b;
    logic [15:0] crc_b;

    logic [15:0] pkt_h = '0;
    logic        pv_h = 1'b0, pr_h, tv_h, trdy_h = 1'b0, busy_h, ovr_h;
    logic [7:0]  txb_h;
    logic [15:0] crc_h;

    tx_packet_framer #(.PACKET_SIZE(72), .BINARY(1'b1), .TERMINATOR(8'h0D)) u_bin (
        .clk(clk), .reset(rst), .packet(pkt_b), .packet_valid(pv_b), .packet_ready(pr_b),
        .tx_byte(txb_b), .tx_valid(tv_b), .tx_ready(trdy_b), .busy(busy_b),
        .crc_out(crc_b), .overrun(ovr_b));

    tx_packet_framer #(.PACKET_SIZE(16), .BINARY(1'b0), .TERMINATOR(8'h0D)) u_hex (
        .clk(clk), .reset(rst), .packet(pkt_h), .packet_valid(pv_h), .packet_ready(pr_h),
        .tx_byte(txb_h), .tx_valid(tv_h), .tx_ready(trdy_h), .busy(busy_h),
        .crc_out(crc_h), .overrun(ovr_h));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int duty_b = 100, duty_h = 100;
    always @(posedge clk) begin
        #1;
        trdy_b = ($urandom_range(0, 99) < duty_b);
        trdy_h = ($urandom_range(0, 99) < duty_h);
    end

    bq_t got_b, got_h, exp_q;
    logic [71:0] acc_h [$];
    logic [15:0] exp_crc;

    logic       hold_b = 1'b0, hold_h = 1'b0;
    logic [7:0] last_b = '0, last_h = '0;
    int         idle_h = 0;
    bit         seen_h = 1'b0;

    always @(negedge clk) begin
        if (hold_b) check("stable_b", {tv_b, txb_b}, {1'b1, last_b});
        if (hold_h) check("stable_h", {tv_h, txb_h}, {1'b1, last_h});
        hold_b = tv_b && !trdy_b && !rst;
        hold_h = tv_h && !trdy_h && !rst;
        last_b = txb_b;
        last_h = txb_h;
        if (tv_b && trdy_b && !rst) got_b.push_back(txb_b);
        if (tv_h && trdy_h && !rst) got_h.push_back(txb_h);
        if (pv_h && pr_h && !rst) acc_h.push_back({56'd0, pkt_h});
        if (!tv_h) begin
            idle_h++;
        end else begin
            if (seen_h && idle_h > 0) check("gap_h", idle_h, 1);
            idle_h = 0;
            seen_h = 1'b1;
        end
    end

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Reference frame: payload characters, CRC-16/CCITT-FALSE over them, CRC rendering, terminator.
    task automatic model(input logic [71:0] p, input int bits, input bit bin);
        bq_t d;
        int  crc;
        if (bin) for (int i = 0; i < bits/8; i++) d.push_back(8'(p >> (bits - 8 - 8*i)));
        else     for (int i = 0; i < bits/4; i++) d.push_back(hexc(int'((p >> (bits - 4 - 4*i)) & 72'hF)));
        crc = 16'hFFFF;
        foreach (d[i]) begin
            crc = crc ^ (int'(d[i]) << 8);
            for (int k = 0; k < 8; k++)
                crc = (crc & 16'h8000) != 0 ? (((crc << 1) ^ 16'h1021) & 16'hFFFF) : ((crc << 1) & 16'hFFFF);
        end
        foreach (d[i]) exp_q.push_back(d[i]);
        if (bin) begin
            exp_q.push_back(8'(crc >> 8));
            exp_q.push_back(8'(crc & 255));
        end else begin
            for (int k = 0; k < 4; k++) exp_q.push_back(hexc((crc >> (12 - 4*k)) & 15));
        end
        exp_q.push_back(8'h0D);
        exp_crc = 16'(crc);
    endtask

    task automatic cmp_q(input string tag, input bq_t g, input bq_t e);
        check({tag, "_len"}, g.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i < g.size()) check($sformatf("%s[%0d]", tag, i), g[i], e[i]);
    endtask

    task automatic run_b(input logic [71:0] p, input int duty, input int pulse_at, input int rst_at);
        int n;
        got_b.delete();
        duty_b = duty;
        pkt_b  = p;
        pv_b   = 1'b1;
        n = 0;
        while (!pr_b && n < 200) begin @(posedge clk); #2; n++; end
        check("accept_b", pr_b, 1);
        @(posedge clk); #2;
        pv_b = 1'b0;
        check("lat_valid_b", tv_b, 1);
        check("lat_byte_b", txb_b, p[71:64]);
        n = 0;
        while (busy_b && n < 2000) begin
            if (rst_at > 0 && got_b.size() == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
                check("rst_tv_b", tv_b, 0);
                check("rst_busy_b", busy_b, 0);
                check("rst_crc_b", crc_b, 0);
                check("rst_ovr_b", ovr_b, 0);
                repeat (3) @(posedge clk);
                #2;
                check("rst_quiet_b", tv_b, 0);
                break;
            end
            pv_b = (n == pulse_at);
            @(posedge clk); #2;
            n++;
        end
        pv_b = 1'b0;
        check("done_b", busy_b, 0);
    endtask

    task automatic run_h(input logic [15:0] first, input int k, input int duty);
        int n, cur;
        got_h.delete();
        acc_h.delete();
        duty_h = duty;
        seen_h = 1'b0;
        idle_h = 0;
        pkt_h  = first;
        pv_h   = 1'b1;
        n = 0;
        cur = 0;
        while (acc_h.size() < k && n < 5000) begin
            @(posedge clk); #2;
            n++;
            if (acc_h.size() > cur) begin
                cur   = acc_h.size();
                pkt_h = 16'($urandom);
                if (cur >= k) pv_h = 1'b0;
            end
        end
        pv_h = 1'b0;
        check("accepts_h", acc_h.size(), k);
        n = 0;
        while (busy_h && n < 5000) begin @(posedge clk); #2; n++; end
        check("done_h", busy_h, 0);
        exp_q.delete();
        foreach (acc_h[i]) model(acc_h[i], 16, 1'b0);
    endtask

    logic [71:0] s123 = "123456789";
    bq_t c1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1, 8'h0D};
    bq_t c2 = '{8'h30, 8'h30, 8'h46, 8'h46};

    initial begin
        int sz;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;
        check("rst_pr_b", pr_b, 1);
        check("rst_tv_b0", tv_b, 0);
        check("rst_txb_b", txb_b, 0);
        check("rst_busy_b0", busy_b, 0);
        check("rst_crc_b0", crc_b, 0);
        check("rst_ovr_b0", ovr_b, 0);
        check("rst_pr_h", pr_h, 1);
        check("rst_tv_h", tv_h, 0);

        run_b(s123, 100, -1, -1);
        exp_q.delete(); model(s123, 72, 1'b1);
        cmp_q("c1_model", got_b, exp_q);
        cmp_q("c1_const", got_b, c1);
        check("c1_crc", crc_b, 16'h29B1);

        run_b(s123, 30, -1, -1);
        cmp_q("c3_bp", got_b, c1);

        run_b(s123, 100, 3, -1);
        cmp_q("c4_frame", got_b, c1);
        check("c4_ovr", ovr_b, 1);
        sz = got_b.size();
        repeat (6) @(posedge clk);
        #2;
        check("c4_no2nd_busy", busy_b, 0);
        check("c4_no2nd_len", got_b.size(), sz);
        run_b(s123, 100, -1, -1);
        cmp_q("c4_again", got_b, c1);
        check("c4_ovr_sticky", ovr_b, 1);

        run_b(s123, 100, -1, 4);
        for (int f = 0; f < 4; f++) begin
            logic [71:0] rp;
            rp = {8'($urandom), $urandom, $urandom};
            run_b(rp, $urandom_range(20, 100), -1, -1);
            exp_q.delete(); model(rp, 72, 1'b1);
            cmp_q($sformatf("rnd_b%0d", f), got_b, exp_q);
            check("rnd_crc_b", crc_b, exp_crc);
        end

        run_h(16'h00FF, 1, 100);
        cmp_q("c2_model", got_h, exp_q);
        check("c2_len", got_h.size(), 9);
        for (int i = 0; i < 4; i++) if (i < got_h.size()) check("c2_const", got_h[i], c2[i]);
        check("c2_crc", crc_h, exp_crc);

        run_h(16'($urandom), 4, 100);
        cmp_q("c6_b2b", got_h, exp_q);
        check("c6_crc", crc_h, exp_crc);
        check("c6_ovr", ovr_h, 0);

        run_h(16'($urandom), 3, 60);
        cmp_q("rnd_h_b2b", got_h, exp_q);
        check("rnd_h_ovr", ovr_h, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end
endmodule
